// File: rtl/shift_pkg.sv
// Shared constants and types for the shift arbiter block.
// Holds default widths, op encodings and the result-holding FSM state type.
// No logic; imported by shift_core and shift_arbiter.
package shift_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_SHAMT_W = 5;

  localparam logic [1:0] OP_SRA = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_core.sv
// Combinational shifter: sra/srl/sll (and rol when SHIFT_ROTATE_EN is defined) plus carry-out.
// Latency 0; purely combinational.
// No flow control; the caller decides when the result is captured.
module shift_core
  import shift_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  output logic [DATA_W-1:0]  result,
  output logic               carry
);

  logic signed [DATA_W-1:0] sdata;
  // One guard bit on each side: the bit shifted out lands in the guard,
  // and a zero shift leaves the guard at 0, which gives carry=0 for free.
  logic [DATA_W:0] rext;
  logic [DATA_W:0] lext;
`ifdef SHIFT_ROTATE_EN
  logic [2*DATA_W-1:0] rot;
`endif

  assign sdata = data;

  // Select the shift result and the last bit shifted out for the requested op.
  always_comb begin
    rext = {data, 1'b0} >> shamt;
    lext = {1'b0, data} << shamt;
`ifdef SHIFT_ROTATE_EN
    rot  = {data, data} << shamt;
`endif
    result = lext[DATA_W-1:0];
    carry  = lext[DATA_W];
    case (op)
      OP_SRA: begin
        result = DATA_W'(sdata >>> shamt);
        carry  = rext[0];
      end
      OP_SRL: begin
        result = rext[DATA_W:1];
        carry  = rext[0];
      end
`ifdef SHIFT_ROTATE_EN
      OP_ROL: begin
        result = rot[2*DATA_W-1:DATA_W];
        carry  = (shamt != '0) ? rot[DATA_W] : 1'b0;
      end
`endif
      default: begin
        // OP_SLL, and OP_ROL when rotate is not built in.
        result = lext[DATA_W-1:0];
        carry  = lext[DATA_W];
      end
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end sharing one shifter; op 11 rotates when SHIFT_ROTATE_EN is defined.
// Latency 1: result registered on the edge after acceptance.
// Accepts when empty or when the held result drains the same cycle; readies low while held or in reset.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [1:0]         req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic [1:0]         req1_op,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic               res_carry,
  output logic               res_id
);

  state_t             state;
  logic               ptr;
  logic               can_accept;
  logic               grant0;
  logic               grant1;
  logic [DATA_W-1:0]  core_data;
  logic [SHAMT_W-1:0] core_shamt;
  logic [1:0]         core_op;
  logic [DATA_W-1:0]  core_result;
  logic               core_carry;

  // A requester's ready only looks at the other requester's valid, so each
  // ready is independent of its own valid; contention resolves via ptr.
  assign can_accept = !rst && ((state == ST_EMPTY) || res_ready);
  assign req0_ready = can_accept && (!ptr || !req1_valid);
  assign req1_ready = can_accept && (ptr || !req0_valid);
  assign grant0     = req0_valid && req0_ready;
  assign grant1     = req1_valid && req1_ready;

  assign core_data  = grant1 ? req1_data  : req0_data;
  assign core_shamt = grant1 ? req1_shamt : req0_shamt;
  assign core_op    = grant1 ? req1_op    : req0_op;

  shift_core #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .data   (core_data),
    .shamt  (core_shamt),
    .op     (core_op),
    .result (core_result),
    .carry  (core_carry)
  );

  // Result FSM: load on grant (covers drain+refill), empty on drain alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_id    <= 1'b0;
      ptr       <= 1'b0;
    end else begin
      if (grant0 || grant1) begin
        state     <= ST_FULL;
        res_valid <= 1'b1;
        res_data  <= core_result;
        res_carry <= core_carry;
        res_id    <= grant1;
        ptr       <= grant0;
      end else if (res_valid && res_ready) begin
        state     <= ST_EMPTY;
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_data;
  logic [4:0]  req0_shamt;
  logic [1:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_data;
  logic [4:0]  req1_shamt;
  logic [1:0]  req1_op;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_carry, res_id;

  int n_checks = 0;
  int n_errors = 0;

  shift_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_shamt (req0_shamt),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_shamt (req1_shamt),
    .req1_op    (req1_op),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_carry  (res_carry),
    .res_id     (res_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Directed single-requester vectors: id, data, shamt, op -> data, carry.
  localparam int NV = 11;
  logic        v_id    [NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] v_data  [NV] = '{32'h80000000, 32'h000000F8, 32'h00000001, 32'hC0000000,
                                32'h80000000, 32'h7FFFFFF0, 32'h80000000, 32'h12345678,
                                32'h80000001, 32'h80000001, 32'hA5A5A5A5};
  logic [4:0]  v_shamt [NV] = '{5'd4, 5'd4, 5'd31, 5'd1, 5'd0, 5'd4, 5'd31, 5'd0, 5'd1, 5'd0, 5'd8};
  logic [1:0]  v_op    [NV] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10,
                                2'b11, 2'b11, 2'b01};
  logic [31:0] v_res   [NV];
  logic        v_cry   [NV];

  initial begin
    v_res = '{32'hF8000000, 32'h0000000F, 32'h80000000, 32'h80000000, 32'h80000000,
              32'h07FFFFFF, 32'h00000001, 32'h12345678,
`ifdef SHIFT_ROTATE_EN
              32'h00000003,
`else
              32'h00000002,
`endif
              32'h80000001, 32'h00A5A5A5};
    v_cry = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_shamt = '0; req0_op = '0;
    req1_valid = 1'b0; req1_data = '0; req1_shamt = '0; req1_op = '0;
    res_ready = 1'b0;
    #2;
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_data",  res_data, 32'd0);
    check("rst_carry", 32'(res_carry), 32'd0);
    check("rst_id",    32'(res_id), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;

    // Single-requester vectors back to back (drain and refill each cycle).
    for (int i = 0; i < NV; i++) begin
      if (v_id[i]) begin
        req1_valid = 1'b1; req1_data = v_data[i]; req1_shamt = v_shamt[i]; req1_op = v_op[i];
        req0_valid = 1'b0;
      end else begin
        req0_valid = 1'b1; req0_data = v_data[i]; req0_shamt = v_shamt[i]; req0_op = v_op[i];
        req1_valid = 1'b0;
      end
      #1;
      check($sformatf("v%0d_ready", i), 32'(v_id[i] ? req1_ready : req0_ready), 32'd1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check($sformatf("v%0d_valid", i), 32'(res_valid), 32'd1);
      check($sformatf("v%0d_data", i),  res_data, v_res[i]);
      check($sformatf("v%0d_carry", i), 32'(res_carry), 32'(v_cry[i]));
      check($sformatf("v%0d_id", i),    32'(res_id), 32'(v_id[i]));
      @(negedge clk);
    end

    // Last vector was granted to req0, so the pointer now favours req1.
    // Reset while FULL must clear outputs at once and restore the pointer.
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h00000001; req0_shamt = 5'd0; req0_op = 2'b10;
    req1_valid = 1'b1; req1_data = 32'h00000002; req1_shamt = 5'd0; req1_op = 2'b10;
    #1;
    check("held_valid", 32'(res_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(res_valid), 32'd0);
    check("arst_data",  res_data, 32'd0);
    check("arst_id",    32'(res_id), 32'd0);
    check("arst_rdy0",  32'(req0_ready), 32'd0);
    check("arst_rdy1",  32'(req1_ready), 32'd0);
    @(posedge clk);
    #1;
    check("arst_hold_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;

    // Both requesters valid every cycle: grants alternate starting with req0.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rr%0d_valid", i), 32'(res_valid), 32'd1);
      check($sformatf("rr%0d_id", i),    32'(res_id), 32'(i % 2));
      check($sformatf("rr%0d_data", i),  res_data, (i % 2) ? 32'd2 : 32'd1);
    end

    // Stall: result from req1 held, both readies low, outputs stable.
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    check("stall_rdy0", 32'(req0_ready), 32'd0);
    check("stall_rdy1", 32'(req1_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_valid", i), 32'(res_valid), 32'd1);
      check($sformatf("stall%0d_id", i),    32'(res_id), 32'd1);
      check($sformatf("stall%0d_data", i),  res_data, 32'd2);
    end

    // Release: drain and refill in the same cycle, req0's turn.
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    check("refill_rdy0", 32'(req0_ready), 32'd1);
    check("refill_rdy1", 32'(req1_ready), 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("refill_valid", 32'(res_valid), 32'd1);
    check("refill_id",    32'(res_id), 32'd0);
    check("refill_data",  res_data, 32'd1);

    // Drain with nothing pending: back to EMPTY.
    @(posedge clk);
    #1;
    check("drain_valid", 32'(res_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/result width (fixed at 32 in this release).
REQ-002 SHALL have parameter SHAMT_W, default 5, meaning shift-amount width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1 each, meaning requester n presents an operation.
REQ-006 SHALL have ports req0_ready/req1_ready, output, 1 each, meaning requester n's operation is accepted this cycle.
REQ-007 SHALL have ports reqN_data, input, DATA_W, meaning value to shift; reqN_shamt, input, SHAMT_W, meaning shift amount; reqN_op, input, 2, meaning 00 sra, 01 srl, 10 sll, 11 sll.
REQ-008 SHALL have ports res_valid, output, 1; res_ready, input, 1; res_data, output, DATA_W; res_carry, output, 1; res_id, output, 1, meaning the result, last bit shifted out, and originating requester.

Function
REQ-009 SHALL define a transfer as valid&&ready high on the same clk edge, on both request and result sides.
REQ-010 SHALL share one shift datapath between the two requesters, accepting at most one request per cycle.
REQ-011 SHALL implement FSM states EMPTY (no result held) and FULL (result held, res_valid=1).
REQ-012 SHALL be able to accept a request when state is EMPTY, or when state is FULL and res_ready=1 (same-cycle drain and refill).
REQ-013 SHALL, when able to accept and only one requester is valid, assert that requester's ready.
REQ-014 SHALL, when able to accept and both are valid, grant the requester selected by a round-robin pointer; pointer reset value selects req0.
REQ-015 SHALL toggle the pointer to the non-granted requester after every grant, and SHALL hold it when no grant occurs.
REQ-016 SHALL keep readyN low while unable to accept; readyN SHALL NOT depend combinationally on reqN_valid of the same requester.
REQ-017 SHALL register res_data, res_carry and res_id one cycle after acceptance (latency 1); they SHALL stay stable while FULL and res_ready=0.
REQ-018 SHALL transition FULL->EMPTY on result transfer with no new grant, EMPTY->FULL on grant, and remain FULL on simultaneous drain and grant.
REQ-019 SHALL compute sra with sign fill, srl with zero fill, and sll with zero fill, shamt in 0..31.
REQ-020 SHALL set carry to data[shamt-1] for right shifts and data[32-shamt] for left shifts when shamt!=0, and to 0 when shamt=0.

Reset
REQ-021 SHALL on rst force state EMPTY, res_valid=0, res_data=0, res_carry=0, res_id=0, pointer=req0, independent of clk.
REQ-022 SHALL discard any held result when rst asserts mid-operation; no request is accepted while rst is high.

Configuration
REQ-023 SHALL, with SHIFT_ROTATE_EN defined, decode op 11 as rotate-left by shamt, with carry = result bit 0 when shamt!=0, else 0.
REQ-024 SHALL, without SHIFT_ROTATE_EN, decode op 11 identically to op 10 (sll).

Structure
REQ-025 SHALL take op encodings (OP_SRA, OP_SRL, OP_SLL, OP_ROL), DATA_W and SHAMT_W defaults from shared package shift_pkg.
REQ-026 SHALL place the combinational shift and carry computation in one sub-module, shift_core; arbitration, FSM and output register stay in shift_arbiter.

Verification
REQ-027 SHALL cover: req0 only, data 0x80000000, shamt 4, op 00 -> next cycle res_data 0xF8000000, carry 0, id 0.
REQ-028 SHALL cover: req1 only, data 0x000000F8, shamt 4, op 01 -> res_data 0x0000000F, carry 1, id 1.
REQ-029 SHALL cover: both valid every cycle, res_ready=1 -> grants alternate 0,1,0,1, one result per cycle, first id 0.
REQ-030 SHALL cover: res_ready=0 with result held, both requesters valid -> both ready low, res_* stable; raising res_ready drains and refills the same cycle.
REQ-031 SHALL cover: data 0x80000001, shamt 1, op 11 -> 0x00000003 carry 1 with SHIFT_ROTATE_EN; 0x00000002 carry 1 without.
REQ-032 SHALL cover: rst asserted while FULL -> res_valid drops immediately, outputs zero, next simultaneous grant goes to req0.
